lcd_ctrl: RTL and testbench

Character-LCD (HD44780-compatible) sequencing controller placed between the memory-mapped LCD register of the `singlecycle` core and the board LCD pins. It accepts one 8-bit command or data byte per valid/ready handshake. It generates the RS/EN/DATA pin sequence with programmable setup, pulse, hold and execution-wait timing. It also runs the mandatory power-up initialisation, so software never bit-bangs EN or polls the busy flag.

---
 rtl/lcd_pkg.sv | 42 ++++
 rtl/lcd_timer.sv | 24 ++
 rtl/lcd_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command constants and helpers for the lcd_ctrl sequencer.
// The init ROM contents here are only used when LCD_CTRL_INIT_EN is defined.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;

    localparam int LCD_INIT_DEPTH = 4;

    // Clear (01) and home (02/03) need the long execution time.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data inside {8'h01, 8'h02, 8'h03});
    endfunction

    function automatic logic [7:0] init_rom_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = LCD_CMD_FUNC_SET;
            2'd1:    b = LCD_CMD_DISP_ON;
            2'd2:    b = LCD_CMD_CLEAR;
            default: b = LCD_CMD_ENTRY;
        endcase
        return b;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed state of lcd_ctrl.
// Loading N-1 on state entry makes o_done true in the N-th cycle of the state.
module lcd_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge i_clk) begin
        if (i_load) begin
            cnt_reg <= i_load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign o_done = (cnt_reg == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: one byte per valid/ready handshake, timed RS/EN/DATA pins.
// Define LCD_CTRL_INIT_EN to compile in the power-up wait and the 4-byte init sequence.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_POWERUP  = 2_500_000,
    parameter int T_SETUP    = 2,
    parameter int T_PULSE    = 12,
    parameter int T_HOLD     = 2,
    parameter int T_CMD_WAIT = 2_000,
    parameter int T_CLR_WAIT = 82_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_vld,
    output logic       o_req_rdy,
    input  logic       i_req_rs,
    input  logic [7:0] i_req_data,
    output logic       o_busy,
    output logic       o_init_done,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic       o_lcd_on
);

    localparam int MAX_T = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_PULSE, T_HOLD)),
                                max2(T_CMD_WAIT, T_CLR_WAIT));
    localparam int CNT_W = $clog2(MAX_T + 1);

    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(T_CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] L_CLR   = CNT_W'(T_CLR_WAIT - 1);

    lcd_state_e       state_reg, state_next;
    logic [7:0]       data_reg, data_next;
    logic             rs_reg, rs_next;
    logic             slow_reg;
    logic             en_reg;
    logic             rdy_reg;
    logic             load_byte;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_done;

`ifdef LCD_CTRL_INIT_EN
    localparam logic [CNT_W-1:0] L_POWERUP = CNT_W'(T_POWERUP - 1);
    logic [2:0] rom_idx_reg;
    logic       start_init;
    logic       set_done;
    logic       init_done_reg;
`endif

    lcd_timer #(.W(CNT_W)) u_timer (
        .i_clk      (i_clk),
        .i_load     (timer_load),
        .i_load_val (timer_val),
        .o_done     (timer_done)
    );

    always_comb begin
        state_next = state_reg;
        load_byte  = 1'b0;
        data_next  = data_reg;
        rs_next    = rs_reg;
        timer_load = 1'b0;
        timer_val  = '0;
`ifdef LCD_CTRL_INIT_EN
        start_init = 1'b0;
        set_done   = 1'b0;
`endif
        case (state_reg)
`ifdef LCD_CTRL_INIT_EN
            ST_POWERUP: if (timer_done) start_init = 1'b1;
            ST_INIT:    start_init = 1'b1;
`else
            ST_POWERUP: state_next = ST_IDLE;
            ST_INIT:    state_next = ST_IDLE;
`endif
            ST_IDLE: begin
                if (i_req_vld && rdy_reg) begin
                    load_byte  = 1'b1;
                    data_next  = i_req_data;
                    rs_next    = i_req_rs;
                    state_next = ST_SETUP;
                    timer_load = 1'b1;
                    timer_val  = L_SETUP;
                end
            end
            ST_SETUP: begin
                if (timer_done) begin
                    state_next = ST_PULSE;
                    timer_load = 1'b1;
                    timer_val  = L_PULSE;
                end
            end
            ST_PULSE: begin
                if (timer_done) begin
                    state_next = ST_HOLD;
                    timer_load = 1'b1;
                    timer_val  = L_HOLD;
                end
            end
            ST_HOLD: begin
                if (timer_done) begin
                    state_next = ST_WAIT;
                    timer_load = 1'b1;
                    timer_val  = slow_reg ? L_CLR : L_CMD;
                end
            end
            ST_WAIT: begin
                if (timer_done) begin
`ifdef LCD_CTRL_INIT_EN
                    if (rom_idx_reg != 3'(LCD_INIT_DEPTH)) begin
                        start_init = 1'b1;
                    end else begin
                        set_done   = 1'b1;
                        state_next = ST_IDLE;
                    end
`else
                    state_next = ST_IDLE;
`endif
                end
            end
            default: state_next = ST_IDLE;
        endcase

`ifdef LCD_CTRL_INIT_EN
        // INIT resolves in the same cycle it is reached, so init bytes get the
        // same SETUP/PULSE/HOLD/WAIT timeline as software requests.
        if (start_init) begin
            load_byte  = 1'b1;
            data_next  = init_rom_byte(rom_idx_reg[1:0]);
            rs_next    = 1'b0;
            state_next = ST_SETUP;
            timer_load = 1'b1;
            timer_val  = L_SETUP;
        end
`endif

        if (i_rst) begin
            timer_load = 1'b1;
`ifdef LCD_CTRL_INIT_EN
            timer_val  = L_POWERUP;
`else
            timer_val  = '0;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_reg <= 8'h00;
            rs_reg   <= 1'b0;
            slow_reg <= 1'b0;
            en_reg   <= 1'b0;
`ifdef LCD_CTRL_INIT_EN
            state_reg     <= ST_POWERUP;
            rdy_reg       <= 1'b0;
            rom_idx_reg   <= 3'd0;
            init_done_reg <= 1'b0;
`else
            state_reg <= ST_IDLE;
            rdy_reg   <= 1'b1;
`endif
        end else begin
            state_reg <= state_next;
            en_reg    <= (state_next == ST_PULSE);
            rdy_reg   <= (state_next == ST_IDLE);
            if (load_byte) begin
                data_reg <= data_next;
                rs_reg   <= rs_next;
                slow_reg <= is_slow_cmd(rs_next, data_next);
            end
`ifdef LCD_CTRL_INIT_EN
            if (start_init) rom_idx_reg <= rom_idx_reg + 3'd1;
            if (set_done) init_done_reg <= 1'b1;
`endif
        end
    end

    assign o_req_rdy  = rdy_reg;
    assign o_busy     = ~rdy_reg;
    assign o_lcd_data = data_reg;
    assign o_lcd_rs   = rs_reg;
    assign o_lcd_en   = en_reg;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_on   = 1'b1;
`ifdef LCD_CTRL_INIT_EN
    assign o_init_done = init_done_reg;
`else
    assign o_init_done = 1'b1;
`endif

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: randomized requests against a timeline model of the pin sequence.
// Works with LCD_CTRL_INIT_EN either defined or undefined.
module tb_lcd_ctrl;

    localparam int T_POWERUP  = 50;
    localparam int T_SETUP    = 2;
    localparam int T_PULSE    = 4;
    localparam int T_HOLD     = 2;
    localparam int T_CMD_WAIT = 10;
    localparam int T_CLR_WAIT = 40;
`ifdef LCD_CTRL_INIT_EN
    localparam bit INIT_BUILD = 1'b1;
`else
    localparam bit INIT_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld = 1'b0;
    logic       rs = 1'b0;
    logic [7:0] din = 8'h00;
    logic       o_req_rdy, o_busy, o_init_done, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;
    logic [7:0] o_lcd_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         len;
        int         unstable;
    } pulse_t;
    pulse_t pulse_q[$];

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_POWERUP (T_POWERUP),
        .T_SETUP   (T_SETUP),
        .T_PULSE   (T_PULSE),
        .T_HOLD    (T_HOLD),
        .T_CMD_WAIT(T_CMD_WAIT),
        .T_CLR_WAIT(T_CLR_WAIT)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req_vld  (vld),
        .o_req_rdy  (o_req_rdy),
        .i_req_rs   (rs),
        .i_req_data (din),
        .o_busy     (o_busy),
        .o_init_done(o_init_done),
        .o_lcd_data (o_lcd_data),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_on   (o_lcd_on)
    );

    // Pulse recorder: one entry per EN high period, with byte/RS seen at the rising edge.
    initial begin
        bit     prev_en;
        bit     e;
        pulse_t cur;
        prev_en = 1'b0;
        cur = '{data: 8'h00, rs: 1'b0, len: 0, unstable: 0};
        forever begin
            @(negedge clk);
            e = (o_lcd_en === 1'b1);
            if (e && !prev_en) begin
                cur = '{data: o_lcd_data, rs: o_lcd_rs, len: 1, unstable: 0};
            end else if (e) begin
                cur.len++;
                if (o_lcd_data !== cur.data || o_lcd_rs !== cur.rs) cur.unstable++;
            end else if (prev_en) begin
                pulse_q.push_back(cur);
            end
            prev_en = e;
        end
    end

    function automatic int exp_wait(input logic r, input logic [7:0] d);
        return (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? T_CLR_WAIT : T_CMD_WAIT;
    endfunction

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (o_req_rdy !== 1'b1 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL %s ready_timeout: rdy=%b after %0d cycles, required 1", name, o_req_rdy, n);
        end
    endtask

    // One request; checks EN window, byte/RS hold, ready return cycle, busy and the pulse record.
    task automatic do_txn(input logic r, input logic [7:0] d, input bit hold_vld, input string name);
        int     exp_rdy, en_lo, en_hi;
        int     en_bad, dat_bad, rdy_bad, busy_bad, rdy_seen;
        pulse_t p;
        exp_rdy  = 1 + T_SETUP + T_PULSE + T_HOLD + exp_wait(r, d);
        en_lo    = 1 + T_SETUP;
        en_hi    = T_SETUP + T_PULSE;
        en_bad   = 0;
        dat_bad  = 0;
        rdy_bad  = 0;
        busy_bad = 0;
        rdy_seen = -1;
        wait_ready(name);
        vld = 1'b1;
        rs  = r;
        din = d;
        @(posedge clk); #1;
        if (!hold_vld) vld = 1'b0;
        for (int k = 1; k <= exp_rdy; k++) begin
            if ((o_lcd_en === 1'b1) != (k >= en_lo && k <= en_hi)) en_bad++;
            if (o_lcd_data !== d || o_lcd_rs !== r) dat_bad++;
            if (o_req_rdy !== (k == exp_rdy)) rdy_bad++;
            if (o_req_rdy === 1'b1 && rdy_seen < 0) rdy_seen = k;
            if (o_busy !== ~o_req_rdy) busy_bad++;
            if (k < exp_rdy) begin
                if (hold_vld) begin
                    din = 8'($urandom);
                    rs  = 1'($urandom);
                end
                @(posedge clk); #1;
            end
        end
        $display("txn %s rs=%0d data=%h ready_at=%0d expected=%0d", name, r, d, rdy_seen, exp_rdy);
        checks++;
        if (en_bad != 0) begin
            errors++;
            $display("FAIL %s en_window: %0d cycles wrong, required 0", name, en_bad);
        end
        checks++;
        if (dat_bad != 0) begin
            errors++;
            $display("FAIL %s data_hold: %0d cycles not %h/rs%0d, required 0", name, dat_bad, d, r);
        end
        checks++;
        if (rdy_bad != 0) begin
            errors++;
            $display("FAIL %s rdy_timing: first ready at %0d (%0d bad cycles), required %0d", name, rdy_seen, rdy_bad, exp_rdy);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s busy: %0d cycles busy==rdy, required 0", name, busy_bad);
        end
        checks++;
        if (pulse_q.size() != 1) begin
            errors++;
            $display("FAIL %s pulse_count: got %0d pulses, required 1", name, pulse_q.size());
            pulse_q.delete();
        end else begin
            p = pulse_q.pop_front();
            checks++;
            if (p.data !== d || p.rs !== r || p.len != T_PULSE || p.unstable != 0) begin
                errors++;
                $display("FAIL %s pulse: data=%h rs=%b len=%0d unstable=%0d, required data=%h rs=%b len=%0d unstable=0",
                         name, p.data, p.rs, p.len, p.unstable, d, r, T_PULSE);
            end
        end
    endtask

    task automatic check_after_reset(input string name);
        logic [13:0] got, want;
        got  = {o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_req_rdy, o_init_done};
        want = {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, INIT_BUILD ? 1'b0 : 1'b1, INIT_BUILD ? 1'b0 : 1'b1};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s outputs {data,rs,rw,en,on,rdy,done}: got %b, required %b", name, got, want);
        end
        $display("txn %s outputs=%b", name, got);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_after_reset("reset");
        rst = 1'b0;
    endtask

    task automatic test_init();
        logic [7:0] rom [4];
        int         exp_cycles, n;
        pulse_t     p;
        rom = '{8'h38, 8'h0C, 8'h01, 8'h06};
        exp_cycles = T_POWERUP;
        for (int i = 0; i < 4; i++) exp_cycles += T_SETUP + T_PULSE + T_HOLD + exp_wait(1'b0, rom[i]);
        n = 0;
        while (o_init_done !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        $display("txn init done_at=%0d expected=%0d pulses=%0d", n, exp_cycles, pulse_q.size());
        checks++;
        if (n != exp_cycles) begin
            errors++;
            $display("FAIL init_done_time: got %0d cycles, required %0d", n, exp_cycles);
        end
        checks++;
        if (pulse_q.size() != 4) begin
            errors++;
            $display("FAIL init_pulse_count: got %0d, required 4", pulse_q.size());
        end
        for (int i = 0; i < 4 && pulse_q.size() > 0; i++) begin
            p = pulse_q.pop_front();
            checks++;
            if (p.data !== rom[i] || p.rs !== 1'b0 || p.len != T_PULSE || p.unstable != 0) begin
                errors++;
                $display("FAIL init_pulse%0d: data=%h rs=%b len=%0d, required data=%h rs=0 len=%0d",
                         i, p.data, p.rs, p.len, rom[i], T_PULSE);
            end
        end
        pulse_q.delete();
    endtask

    task automatic test_idle_quiet();
        int en_seen, rdy_low;
        en_seen = 0;
        rdy_low = 0;
        for (int k = 0; k < 60; k++) begin
            if (o_lcd_en !== 1'b0) en_seen++;
            if (o_req_rdy !== 1'b1 || o_init_done !== 1'b1) rdy_low++;
            @(posedge clk); #1;
        end
        $display("txn idle_quiet en_cycles=%0d not_ready_cycles=%0d", en_seen, rdy_low);
        checks++;
        if (en_seen != 0 || pulse_q.size() != 0) begin
            errors++;
            $display("FAIL idle_quiet_en: %0d EN cycles, %0d pulses, required 0", en_seen, pulse_q.size());
        end
        checks++;
        if (rdy_low != 0) begin
            errors++;
            $display("FAIL idle_quiet_rdy: %0d cycles not ready/done, required 0", rdy_low);
        end
    endtask

    task automatic test_directed();
        do_txn(1'b1, 8'h41, 1'b0, "data41");
        do_txn(1'b0, 8'h01, 1'b0, "clear01");
        do_txn(1'b0, 8'h80, 1'b0, "ddram80");
        do_txn(1'b0, 8'h02, 1'b0, "home02");
        do_txn(1'b1, 8'h01, 1'b0, "data01");
    endtask

    task automatic test_random();
        logic       r;
        logic [7:0] d;
        for (int i = 0; i < 12; i++) begin
            r = 1'($urandom);
            d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            do_txn(r, d, 1'b0, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            do_txn(1'($urandom), 8'($urandom), 1'b1, $sformatf("b2b%0d", i));
        end
        vld = 1'b0;
    endtask

    task automatic test_reset_mid_pulse();
        int     n;
        pulse_t p;
        wait_ready("midrst");
        vld = 1'b1;
        rs  = 1'b1;
        din = 8'h55;
        @(posedge clk); #1;
        vld = 1'b0;
        repeat (T_SETUP + 1) @(posedge clk);
        #1;
        checks++;
        if (o_lcd_en !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_pulse: en=%b, required 1", o_lcd_en);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_after_reset("midrst");
        rst = 1'b0;
        @(negedge clk); #1;
        pulse_q.delete();
        if (INIT_BUILD) begin
            n = 0;
            while (pulse_q.size() == 0 && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            checks++;
            if (pulse_q.size() == 0) begin
                errors++;
                $display("FAIL midrst_restart: no pulse after %0d cycles, required 8'h38", n);
            end else begin
                p = pulse_q.pop_front();
                $display("txn midrst_restart first_pulse=%h rs=%b", p.data, p.rs);
                checks++;
                if (p.data !== 8'h38 || p.rs !== 1'b0) begin
                    errors++;
                    $display("FAIL midrst_restart: data=%h rs=%b, required 38 rs=0", p.data, p.rs);
                end
            end
        end else begin
            do_txn(1'b1, 8'h5A, 1'b0, "after_midrst");
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        if (INIT_BUILD) test_init();
        else test_idle_quiet();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
